// File: rtl/avalon_arb_pkg.sv
// Shared types and constants for the Avalon read/write arbiter.
//   arb_state_t : grant state machine encoding (IDLE, GNT_RD, GNT_WR)
//   GNT_*       : encodings driven on Grant_o
//   grant_code  : maps an arbiter state to its Grant_o encoding
package avalon_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_RD = 2'd1,
    GNT_WR = 2'd2
  } arb_state_t;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_RD_C = 2'b01;
  localparam logic [1:0] GNT_WR_C = 2'b10;

  function automatic logic [1:0] grant_code(input arb_state_t s);
    case (s)
      IDLE:    return GNT_NONE;
      GNT_RD:  return GNT_RD_C;
      GNT_WR:  return GNT_WR_C;
      default: return GNT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/avalon_rw_arbiter_if.sv
// Bundle of every bus signal around the arbiter: the read requester, the
// write requester, the shared Avalon-MM master port and the grant status.
//   master : arbiter view (requester commands and slave responses in,
//            Avalon command, requester waitreqs, read data and grant out)
//   slave  : environment view (the mirror image)
interface avalon_rw_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 512,
  parameter int BE_W   = 64
);

  logic [ADDR_W-1:0] RdMstAddr_i;
  logic              RdMstRead_i;
  logic [BE_W-1:0]   RdMstByteEnable_i;
  logic              RdMstLock_i;
  logic [DATA_W-1:0] RdMstReadData_o;
  logic              RdMstWaitReq_o;

  logic [ADDR_W-1:0] WrMstAddr_i;
  logic              WrMstWrite_i;
  logic [BE_W-1:0]   WrMstByteEnable_i;
  logic [DATA_W-1:0] WrMstWriteData_i;
  logic              WrMstLock_i;
  logic              WrMstWaitReq_o;

  logic [ADDR_W-1:0] AvalonAddr_o;
  logic              AvalonRead_o;
  logic              AvalonWrite_o;
  logic [BE_W-1:0]   AvalonByteEnable_o;
  logic [DATA_W-1:0] AvalonWriteData_o;
  logic              AvalonLock_o;
  logic [DATA_W-1:0] AvalonReadData_i;
  logic              AvalonWaitReq_i;

  logic [1:0]        Grant_o;

  modport master (
    input  RdMstAddr_i, RdMstRead_i, RdMstByteEnable_i, RdMstLock_i,
    output RdMstReadData_o, RdMstWaitReq_o,
    input  WrMstAddr_i, WrMstWrite_i, WrMstByteEnable_i, WrMstWriteData_i, WrMstLock_i,
    output WrMstWaitReq_o,
    output AvalonAddr_o, AvalonRead_o, AvalonWrite_o, AvalonByteEnable_o,
    output AvalonWriteData_o, AvalonLock_o,
    input  AvalonReadData_i, AvalonWaitReq_i,
    output Grant_o
  );

  modport slave (
    output RdMstAddr_i, RdMstRead_i, RdMstByteEnable_i, RdMstLock_i,
    input  RdMstReadData_o, RdMstWaitReq_o,
    output WrMstAddr_i, WrMstWrite_i, WrMstByteEnable_i, WrMstWriteData_i, WrMstLock_i,
    input  WrMstWaitReq_o,
    input  AvalonAddr_o, AvalonRead_o, AvalonWrite_o, AvalonByteEnable_o,
    input  AvalonWriteData_o, AvalonLock_o,
    output AvalonReadData_i, AvalonWaitReq_i,
    input  Grant_o
  );

endinterface

// File: rtl/arb_streak_counter.sv
// Saturating 8-bit count of consecutive completed writes while a read waits.
//   clk, rstn : clock, asynchronous active-low reset
//   inc       : a write completed with a read pending (saturates at MAX)
//   clr       : restart the streak (takes priority over inc)
//   at_limit  : registered flag, high when the count equals MAX
module arb_streak_counter #(
  parameter int unsigned MAX = 4
) (
  input  logic clk,
  input  logic rstn,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  localparam logic [7:0] MAX_C = 8'(MAX);

  logic [7:0] cnt_r;
  logic [7:0] cnt_nxt_s;
  logic       at_limit_r;

  // Next count: clear wins, otherwise count up until the limit is reached
  always_comb begin
    cnt_nxt_s = cnt_r;
    if (clr) begin
      cnt_nxt_s = 8'd0;
    end else if (inc && (cnt_r != MAX_C)) begin
      cnt_nxt_s = cnt_r + 8'd1;
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Count and limit flag registers; the flag tracks the next count so it is
  // valid in the same cycle the count changes
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_r      <= 8'd0;
      at_limit_r <= 1'b0;
    end else begin
      cnt_r      <= cnt_nxt_s;
      at_limit_r <= (cnt_nxt_s == MAX_C);
    end
  end

  assign at_limit = at_limit_r;

endmodule

// File: rtl/avalon_rw_arbiter.sv
// Shares one Avalon-MM master port between a read-only and a write-only
// requester. A registered grant is held until the slave accepts the transfer;
// a granted lock keeps the grant across transfers, and a write-streak counter
// hands the port to a pending read after MAX_WR_STREAK completed writes.
//   clk, rstn : clock, asynchronous active-low reset
//   bus       : requester commands/waitreqs, Avalon command/response, Grant_o
module avalon_rw_arbiter
  import avalon_arb_pkg::*;
#(
  parameter int unsigned MAX_WR_STREAK = 4
) (
  input logic                clk,
  input logic                rstn,
  avalon_rw_arbiter_if.master bus
);

  arb_state_t state_r;
  arb_state_t state_nxt_s;

  logic rd_req_s;
  logic wr_req_s;
  logic slv_wait_s;
  logic rd_done_s;
  logic wr_done_s;
  logic streak_inc_s;
  logic streak_clr_s;
  logic streak_limit_s;

  assign rd_req_s   = bus.RdMstRead_i;
  assign wr_req_s   = bus.WrMstWrite_i;
  assign slv_wait_s = bus.AvalonWaitReq_i;

  // A transfer completes when the granted request is still up and the slave
  // has stopped waiting
  assign rd_done_s = (state_r == GNT_RD) && rd_req_s && !slv_wait_s;
  assign wr_done_s = (state_r == GNT_WR) && wr_req_s && !slv_wait_s;

  // Only writes that overtake a waiting read count toward the streak; the
  // streak ends once a read gets through or no read is waiting any more
  assign streak_inc_s = wr_done_s && rd_req_s;
  assign streak_clr_s = rd_done_s || ((state_r == IDLE) && !rd_req_s);

  arb_streak_counter #(
    .MAX (MAX_WR_STREAK)
  ) u_streak (
    .clk      (clk),
    .rstn     (rstn),
    .inc      (streak_inc_s),
    .clr      (streak_clr_s),
    .at_limit (streak_limit_s)
  );

  // Grant state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Arbitration and grant hold/release
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        // Writes win ties unless they have already starved a read long enough
        if (wr_req_s && !(rd_req_s && streak_limit_s)) begin
          state_nxt_s = GNT_WR;
        end else if (rd_req_s) begin
          state_nxt_s = GNT_RD;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      GNT_RD: begin
        if (!rd_req_s) begin
          state_nxt_s = IDLE;
        end else if (!slv_wait_s) begin
          state_nxt_s = bus.RdMstLock_i ? GNT_RD : IDLE;
        end else begin
          state_nxt_s = GNT_RD;
        end
      end
      GNT_WR: begin
        // Lock keeps the write grant even when the streak limit is reached
        if (!wr_req_s) begin
          state_nxt_s = IDLE;
        end else if (!slv_wait_s) begin
          state_nxt_s = bus.WrMstLock_i ? GNT_WR : IDLE;
        end else begin
          state_nxt_s = GNT_WR;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Bus mux: only the granted requester reaches the Avalon port
  always_comb begin
    bus.AvalonAddr_o       = '0;
    bus.AvalonRead_o       = 1'b0;
    bus.AvalonWrite_o      = 1'b0;
    bus.AvalonByteEnable_o = '0;
    bus.AvalonWriteData_o  = '0;
    bus.AvalonLock_o       = 1'b0;
    bus.RdMstWaitReq_o     = 1'b1;
    bus.WrMstWaitReq_o     = 1'b1;
    case (state_r)
      GNT_RD: begin
        bus.AvalonAddr_o       = bus.RdMstAddr_i;
        bus.AvalonRead_o       = bus.RdMstRead_i;
        bus.AvalonByteEnable_o = bus.RdMstByteEnable_i;
        bus.AvalonLock_o       = bus.RdMstLock_i;
        bus.RdMstWaitReq_o     = slv_wait_s;
      end
      GNT_WR: begin
        bus.AvalonAddr_o       = bus.WrMstAddr_i;
        bus.AvalonWrite_o      = bus.WrMstWrite_i;
        bus.AvalonByteEnable_o = bus.WrMstByteEnable_i;
        bus.AvalonWriteData_o  = bus.WrMstWriteData_i;
        bus.AvalonLock_o       = bus.WrMstLock_i;
        bus.WrMstWaitReq_o     = slv_wait_s;
      end
      IDLE: begin
        bus.AvalonRead_o  = 1'b0;
        bus.AvalonWrite_o = 1'b0;
      end
      default: begin
        bus.AvalonRead_o  = 1'b0;
        bus.AvalonWrite_o = 1'b0;
      end
    endcase
  end

  assign bus.Grant_o         = grant_code(state_r);
  assign bus.RdMstReadData_o = bus.AvalonReadData_i;

endmodule

// File: tb/tb_avalon_rw_arbiter.sv
module tb_avalon_rw_arbiter;

  localparam int ADDR_W = 64;
  localparam int DATA_W = 512;
  localparam int BE_W   = 64;
  localparam int MAX    = 4;

  logic clk = 1'b0;
  logic rstn;

  always #5 clk = ~clk;

  avalon_rw_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W)) bus ();

  avalon_rw_arbiter #(.MAX_WR_STREAK(MAX)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: who holds the port (0 none, 1 read, 2 write) and how
  // many writes have overtaken a waiting read
  int mdl_gnt = 0;
  int mdl_streak = 0;

  function automatic logic [DATA_W-1:0] rand_data();
    logic [DATA_W-1:0] d;
    for (int i = 0; i < DATA_W / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [1:0] model_grant();
    if (mdl_gnt == 1) return 2'b01;
    else if (mdl_gnt == 2) return 2'b10;
    else return 2'b00;
  endfunction

  task automatic idle_inputs();
    bus.RdMstAddr_i       = '0;
    bus.RdMstRead_i       = 1'b0;
    bus.RdMstByteEnable_i = '0;
    bus.RdMstLock_i       = 1'b0;
    bus.WrMstAddr_i       = '0;
    bus.WrMstWrite_i      = 1'b0;
    bus.WrMstByteEnable_i = '0;
    bus.WrMstWriteData_i  = '0;
    bus.WrMstLock_i       = 1'b0;
    bus.AvalonReadData_i  = '0;
    bus.AvalonWaitReq_i   = 1'b0;
  endtask

  // Advance the model by the rules for the current inputs, then clock once
  task automatic tick();
    logic rd, wr, wt;
    int nxt;
    rd = bus.RdMstRead_i;
    wr = bus.WrMstWrite_i;
    wt = bus.AvalonWaitReq_i;
    nxt = mdl_gnt;
    if (mdl_gnt == 0) begin
      if (wr && !(rd && mdl_streak == MAX)) nxt = 2;
      else if (rd) nxt = 1;
      else nxt = 0;
      if (!rd) mdl_streak = 0;
    end else if (mdl_gnt == 1) begin
      if (!rd) nxt = 0;
      else if (!wt) begin
        mdl_streak = 0;
        nxt = bus.RdMstLock_i ? 1 : 0;
      end
    end else begin
      if (!wr) nxt = 0;
      else if (!wt) begin
        if (rd && mdl_streak < MAX) mdl_streak = mdl_streak + 1;
        nxt = bus.WrMstLock_i ? 2 : 0;
      end
    end
    mdl_gnt = nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    idle_inputs();
    bus.RdMstRead_i  = 1'b1;
    bus.WrMstWrite_i = 1'b1;
    #2;
    n_vec++;
    if (bus.Grant_o !== 2'b00) begin
      n_err++; $display("FAIL reset_grant got=%b exp=00", bus.Grant_o);
    end
    n_vec++;
    if ({bus.AvalonRead_o, bus.AvalonWrite_o, bus.AvalonLock_o} !== 3'b000) begin
      n_err++; $display("FAIL reset_cmd got=%b exp=000", {bus.AvalonRead_o, bus.AvalonWrite_o, bus.AvalonLock_o});
    end
    n_vec++;
    if ({bus.RdMstWaitReq_o, bus.WrMstWaitReq_o} !== 2'b11) begin
      n_err++; $display("FAIL reset_waitreq got=%b exp=11", {bus.RdMstWaitReq_o, bus.WrMstWaitReq_o});
    end
    n_vec++;
    if (bus.AvalonAddr_o !== '0 || bus.AvalonByteEnable_o !== '0 || bus.AvalonWriteData_o !== '0) begin
      n_err++; $display("FAIL reset_fields got addr=%h be=%h exp=0", bus.AvalonAddr_o, bus.AvalonByteEnable_o);
    end
    @(posedge clk);
    #1;
    rstn = 1'b1;
    idle_inputs();
    mdl_gnt = 0;
    mdl_streak = 0;
    // Reset asserted while a write is stalled by the slave
    bus.WrMstWrite_i     = 1'b1;
    bus.WrMstAddr_i      = rand64();
    bus.WrMstWriteData_i = rand_data();
    bus.AvalonWaitReq_i  = 1'b1;
    #2;
    tick();
    #2;
    n_vec++;
    if (bus.AvalonWrite_o !== 1'b1) begin
      n_err++; $display("FAIL midwr_write_before got=%b exp=1", bus.AvalonWrite_o);
    end
    rstn = 1'b0;
    #1;
    n_vec++;
    if (bus.AvalonWrite_o !== 1'b0 || bus.Grant_o !== 2'b00) begin
      n_err++; $display("FAIL midwr_async got write=%b grant=%b exp write=0 grant=00", bus.AvalonWrite_o, bus.Grant_o);
    end
    n_vec++;
    if ({bus.RdMstWaitReq_o, bus.WrMstWaitReq_o} !== 2'b11) begin
      n_err++; $display("FAIL midwr_waitreq got=%b exp=11", {bus.RdMstWaitReq_o, bus.WrMstWaitReq_o});
    end
    mdl_gnt = 0;
    mdl_streak = 0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    idle_inputs();
    tick();
  endtask

  task automatic test_single_read();
    logic [DATA_W-1:0] rdata;
    idle_inputs();
    bus.RdMstRead_i       = 1'b1;
    bus.RdMstAddr_i       = 64'h0000_0000_0000_1000;
    bus.RdMstByteEnable_i = rand64();
    bus.AvalonWaitReq_i   = 1'b1;
    #2;
    n_vec++;
    if (bus.Grant_o !== 2'b00 || bus.AvalonRead_o !== 1'b0) begin
      n_err++; $display("FAIL rd_idle got grant=%b read=%b exp 00/0", bus.Grant_o, bus.AvalonRead_o);
    end
    tick();
    for (int k = 0; k < 3; k++) begin
      bus.AvalonWaitReq_i  = (k < 2);
      rdata                = rand_data();
      bus.AvalonReadData_i = rdata;
      #2;
      n_vec++;
      if (bus.AvalonRead_o !== 1'b1 || bus.Grant_o !== 2'b01 || bus.AvalonAddr_o !== 64'h1000) begin
        n_err++; $display("FAIL rd_cmd cyc=%0d got read=%b grant=%b addr=%h exp 1/01/1000", k, bus.AvalonRead_o, bus.Grant_o, bus.AvalonAddr_o);
      end
      n_vec++;
      if (bus.RdMstWaitReq_o !== (k < 2) || bus.WrMstWaitReq_o !== 1'b1) begin
        n_err++; $display("FAIL rd_waitreq cyc=%0d got rd=%b wr=%b exp rd=%b wr=1", k, bus.RdMstWaitReq_o, bus.WrMstWaitReq_o, (k < 2));
      end
      if (k == 2) begin
        n_vec++;
        if (bus.RdMstReadData_o !== rdata) begin
          n_err++; $display("FAIL rd_data got=%h exp=%h", bus.RdMstReadData_o, rdata);
        end
      end
      tick();
    end
    bus.RdMstRead_i = 1'b0;
    #2;
    n_vec++;
    if (bus.Grant_o !== 2'b00 || bus.AvalonRead_o !== 1'b0) begin
      n_err++; $display("FAIL rd_after got grant=%b read=%b exp 00/0", bus.Grant_o, bus.AvalonRead_o);
    end
    tick();
  endtask

  task automatic test_contention();
    logic [DATA_W-1:0] wd;
    logic [63:0] ra, wa;
    idle_inputs();
    wd = rand_data();
    ra = rand64();
    wa = rand64();
    bus.RdMstRead_i      = 1'b1;
    bus.RdMstAddr_i      = ra;
    bus.WrMstWrite_i     = 1'b1;
    bus.WrMstAddr_i      = wa;
    bus.WrMstWriteData_i = wd;
    #2;
    tick();
    #2;
    n_vec++;
    if (bus.Grant_o !== 2'b10 || bus.AvalonWrite_o !== 1'b1 || bus.AvalonRead_o !== 1'b0) begin
      n_err++; $display("FAIL cont_wr_first got grant=%b wr=%b rd=%b exp 10/1/0", bus.Grant_o, bus.AvalonWrite_o, bus.AvalonRead_o);
    end
    n_vec++;
    if (bus.AvalonWriteData_o !== wd || bus.AvalonAddr_o !== wa) begin
      n_err++; $display("FAIL cont_wr_fields got addr=%h exp=%h", bus.AvalonAddr_o, wa);
    end
    n_vec++;
    if (bus.WrMstWaitReq_o !== 1'b0 || bus.RdMstWaitReq_o !== 1'b1) begin
      n_err++; $display("FAIL cont_waitreq got wr=%b rd=%b exp 0/1", bus.WrMstWaitReq_o, bus.RdMstWaitReq_o);
    end
    tick();
    bus.WrMstWrite_i = 1'b0;
    #2;
    n_vec++;
    if (bus.Grant_o !== 2'b00) begin
      n_err++; $display("FAIL cont_bubble got grant=%b exp=00", bus.Grant_o);
    end
    tick();
    #2;
    n_vec++;
    if (bus.Grant_o !== 2'b01 || bus.AvalonRead_o !== 1'b1 || bus.AvalonAddr_o !== ra || bus.AvalonWriteData_o !== '0) begin
      n_err++; $display("FAIL cont_rd_second got grant=%b rd=%b addr=%h exp 01/1/%h", bus.Grant_o, bus.AvalonRead_o, bus.AvalonAddr_o, ra);
    end
    tick();
    bus.RdMstRead_i = 1'b0;
    #2;
    tick();
  endtask

  task automatic test_starvation();
    string obs;
    obs = "";
    idle_inputs();
    tick();
    tick();
    bus.RdMstRead_i  = 1'b1;
    bus.WrMstWrite_i = 1'b1;
    for (int c = 0; c < 18; c++) begin
      bus.WrMstWriteData_i = rand_data();
      bus.WrMstAddr_i      = rand64();
      #2;
      n_vec++;
      if (bus.Grant_o !== model_grant()) begin
        n_err++; $display("FAIL starve_grant cyc=%0d got=%b exp=%b", c, bus.Grant_o, model_grant());
      end
      if (bus.Grant_o == 2'b10 && bus.AvalonWrite_o && !bus.AvalonWaitReq_i) obs = {obs, "W"};
      if (bus.Grant_o == 2'b01 && bus.AvalonRead_o && !bus.AvalonWaitReq_i) obs = {obs, "R"};
      tick();
    end
    n_vec++;
    if (obs != "WWWWRWWWW") begin
      n_err++; $display("FAIL starve_order got=%s exp=WWWWRWWWW", obs);
    end
    idle_inputs();
    tick();
    tick();
  endtask

  task automatic test_lock();
    string obs;
    logic [1:0] exp_g [0:5];
    exp_g = '{2'b00, 2'b10, 2'b10, 2'b10, 2'b00, 2'b01};
    obs = "";
    idle_inputs();
    tick();
    bus.RdMstRead_i = 1'b1;
    for (int c = 0; c < 6; c++) begin
      bus.WrMstLock_i      = (c < 3);
      bus.WrMstWrite_i     = (c < 4);
      bus.WrMstWriteData_i = rand_data();
      #2;
      n_vec++;
      if (bus.Grant_o !== exp_g[c]) begin
        n_err++; $display("FAIL lock_grant cyc=%0d got=%b exp=%b", c, bus.Grant_o, exp_g[c]);
      end
      n_vec++;
      if (bus.AvalonLock_o !== (c == 1 || c == 2)) begin
        n_err++; $display("FAIL lock_out cyc=%0d got=%b exp=%b", c, bus.AvalonLock_o, (c == 1 || c == 2));
      end
      if (bus.Grant_o == 2'b10 && bus.AvalonWrite_o && !bus.AvalonWaitReq_i) obs = {obs, "W"};
      if (bus.Grant_o == 2'b01 && bus.AvalonRead_o && !bus.AvalonWaitReq_i) obs = {obs, "R"};
      tick();
    end
    n_vec++;
    if (obs != "WWWR") begin
      n_err++; $display("FAIL lock_order got=%s exp=WWWR", obs);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_withdrawal();
    string obs;
    logic [1:0] exp_g [0:12];
    exp_g = '{2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00,
              2'b10, 2'b10, 2'b00, 2'b10, 2'b00, 2'b01};
    obs = "";
    idle_inputs();
    tick();
    tick();
    bus.RdMstRead_i = 1'b1;
    for (int c = 0; c < 13; c++) begin
      bus.WrMstWrite_i    = (c != 8);
      bus.AvalonWaitReq_i = (c == 7 || c == 8);
      #2;
      n_vec++;
      if (bus.Grant_o !== exp_g[c]) begin
        n_err++; $display("FAIL wdraw_grant cyc=%0d got=%b exp=%b", c, bus.Grant_o, exp_g[c]);
      end
      if (c == 8) begin
        n_vec++;
        if (bus.AvalonWrite_o !== 1'b0 || bus.WrMstWaitReq_o !== 1'b1) begin
          n_err++; $display("FAIL wdraw_cmd got write=%b waitreq=%b exp 0/1", bus.AvalonWrite_o, bus.WrMstWaitReq_o);
        end
      end
      if (bus.Grant_o == 2'b10 && bus.AvalonWrite_o && !bus.AvalonWaitReq_i) obs = {obs, "W"};
      if (bus.Grant_o == 2'b01 && bus.AvalonRead_o && !bus.AvalonWaitReq_i) obs = {obs, "R"};
      tick();
    end
    n_vec++;
    if (obs != "WWWWR") begin
      n_err++; $display("FAIL wdraw_order got=%s exp=WWWWR", obs);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_random();
    logic [63:0] exp_addr, exp_be;
    logic [DATA_W-1:0] exp_wd;
    logic [4:0] exp_ctl, got_ctl;
    logic wt;
    for (int c = 0; c < 400; c++) begin
      bus.RdMstRead_i       = ($urandom_range(0, 9) < 7);
      bus.WrMstWrite_i      = ($urandom_range(0, 9) < 7);
      bus.RdMstLock_i       = ($urandom_range(0, 3) == 0);
      bus.WrMstLock_i       = ($urandom_range(0, 3) == 0);
      bus.AvalonWaitReq_i   = ($urandom_range(0, 9) < 3);
      bus.RdMstAddr_i       = rand64();
      bus.WrMstAddr_i       = rand64();
      bus.RdMstByteEnable_i = rand64();
      bus.WrMstByteEnable_i = rand64();
      bus.WrMstWriteData_i  = rand_data();
      bus.AvalonReadData_i  = rand_data();
      #2;
      wt = bus.AvalonWaitReq_i;
      exp_addr = '0;
      exp_be   = '0;
      exp_wd   = '0;
      exp_ctl  = 5'b00011;
      if (mdl_gnt == 1) begin
        exp_addr = bus.RdMstAddr_i;
        exp_be   = bus.RdMstByteEnable_i;
        exp_ctl  = {bus.RdMstRead_i, 1'b0, bus.RdMstLock_i, wt, 1'b1};
      end else if (mdl_gnt == 2) begin
        exp_addr = bus.WrMstAddr_i;
        exp_be   = bus.WrMstByteEnable_i;
        exp_wd   = bus.WrMstWriteData_i;
        exp_ctl  = {1'b0, bus.WrMstWrite_i, bus.WrMstLock_i, 1'b1, wt};
      end
      got_ctl = {bus.AvalonRead_o, bus.AvalonWrite_o, bus.AvalonLock_o, bus.RdMstWaitReq_o, bus.WrMstWaitReq_o};
      n_vec++;
      if (bus.Grant_o !== model_grant()) begin
        n_err++; $display("FAIL rand_grant cyc=%0d got=%b exp=%b", c, bus.Grant_o, model_grant());
      end
      n_vec++;
      if (got_ctl !== exp_ctl) begin
        n_err++; $display("FAIL rand_ctl cyc=%0d got=%b exp=%b (rd,wr,lock,rdwait,wrwait)", c, got_ctl, exp_ctl);
      end
      n_vec++;
      if (bus.AvalonAddr_o !== exp_addr || bus.AvalonByteEnable_o !== exp_be) begin
        n_err++; $display("FAIL rand_addr_be cyc=%0d got=%h/%h exp=%h/%h", c, bus.AvalonAddr_o, bus.AvalonByteEnable_o, exp_addr, exp_be);
      end
      n_vec++;
      if (bus.AvalonWriteData_o !== exp_wd) begin
        n_err++; $display("FAIL rand_wdata cyc=%0d got=%h exp=%h", c, bus.AvalonWriteData_o, exp_wd);
      end
      n_vec++;
      if (bus.RdMstReadData_o !== bus.AvalonReadData_i) begin
        n_err++; $display("FAIL rand_rdata cyc=%0d got=%h exp=%h", c, bus.RdMstReadData_o, bus.AvalonReadData_i);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_contention();
    test_starvation();
    test_lock();
    test_withdrawal();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
